// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, M-group selects and control state for alu_muldiv
package alu_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00100;
  localparam logic [4:0] OP_SLTU = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SRL  = 5'b00111;
  localparam logic [4:0] OP_SRA  = 5'b10111;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  typedef enum logic {IDLE, DIV} state_e;
endpackage

// File: rtl/div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per cycle
// Ports: clk, rst (sync, active-high); start_i loads dividend_i/divisor_i;
// done_o is high whenever no iteration is pending; quot_o/rem_o unsigned results.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);
  localparam int CW = $clog2(XLEN + 1);
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quot_q, rem_q, dvs_q;
  logic [XLEN:0]   rem_sh, diff;
  // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder
  assign rem_sh = {rem_q, quot_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign done_o = cnt_q == '0;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      cnt_q  <= CW'(XLEN);
      quot_q <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - CW'(1);
      quot_q <= {quot_q[XLEN-2:0], !diff[XLEN]};
      rem_q  <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    end
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered-output integer ALU with optional multiply/iterative divide
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake with
// alu_op, funct7, funct3, a, b; out_valid/out_ready result handshake with result
// and zero; busy marks an iterating division.
// Macro ALU_MULDIV_EN compiles in the M group; without it M ops return 0.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);
  logic [SHAMT_W-1:0] sh;
  logic [XLEN-1:0]    base_res, new_res, div_res, res_n, result_q, result_d;
  logic               out_valid_q, out_valid_d, zero_q, zero_d;
  logic               accept, start, done, load;
  assign sh = b[SHAMT_W-1:0];
  always_comb begin
    case (alu_op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_SLL:  base_res = a << sh;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  base_res = a ^ b;
      OP_SRL:  base_res = a >> sh;
      OP_SRA:  base_res = $signed(a) >>> sh;
      OP_OR:   base_res = a | b;
      OP_AND:  base_res = a & b;
      default: base_res = '0;
    endcase
  end
`ifdef ALU_MULDIV_EN
  state_e            state_q, state_d;
  logic              is_m, sgn, dz, ovf, qneg_q, rneg_q, rem_op_q, div_done;
  logic [2*XLEN-1:0] p_ss, p_su, p_uu;
  logic [XLEN-1:0]   m_res, a_mag, b_mag, quot, rem;
  logic              unused_lo;
  assign is_m = funct7 == FUNCT7_MULDIV;
  assign sgn  = !funct3[0];
  assign dz   = b == '0;
  assign ovf  = sgn && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
  // Sign-extended operands multiplied modulo 2^(2*XLEN) give the exact signed products
  assign p_ss = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
  assign p_su = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{1'b0}}, b};
  assign p_uu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  assign unused_lo = ^p_su[XLEN-1:0];
  assign a_mag = (sgn && a[XLEN-1]) ? -a : a;
  assign b_mag = (sgn && b[XLEN-1]) ? -b : b;
  // Divide ops only take the latency-1 path for divide-by-zero or signed overflow
  always_comb begin
    case (funct3)
      F3_MUL:          m_res = p_ss[XLEN-1:0];
      F3_MULH:         m_res = p_ss[2*XLEN-1:XLEN];
      F3_MULHSU:       m_res = p_su[2*XLEN-1:XLEN];
      F3_MULHU:        m_res = p_uu[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: m_res = dz ? '1 : a;
      default:         m_res = dz ? a : '0;
    endcase
  end
  assign new_res  = is_m ? m_res : base_res;
  assign start    = accept && is_m && funct3[2] && !dz && !ovf;
  assign done     = state_q == DIV && div_done;
  assign div_res  = rem_op_q ? (rneg_q ? -rem : rem) : (qneg_q ? -quot : quot);
  assign state_d  = start ? DIV : done ? IDLE : state_q;
  assign in_ready = state_q == IDLE && (!out_valid_q || out_ready);
  assign busy     = state_q == DIV;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (start) begin
      qneg_q   <= sgn && (a[XLEN-1] ^ b[XLEN-1]);
      rneg_q   <= sgn && a[XLEN-1];
      rem_op_q <= funct3[1];
    end
  end
  div_iter #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .done_o     (div_done),
    .quot_o     (quot),
    .rem_o      (rem)
  );
`else
  logic unused_f3;
  assign unused_f3 = ^funct3;
  assign new_res   = funct7 == FUNCT7_MULDIV ? '0 : base_res;
  assign start     = 1'b0;
  assign done      = 1'b0;
  assign div_res   = '0;
  assign in_ready  = !out_valid_q || out_ready;
  assign busy      = 1'b0;
`endif
  assign accept      = in_valid && in_ready;
  assign load        = done || (accept && !start);
  assign res_n       = done ? div_res : new_res;
  assign result_d    = load ? res_n : result_q;
  assign zero_d      = load ? res_n == '0 : zero_q;
  assign out_valid_d = load || (out_valid_q && !out_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
endmodule
